// File: rtl/mc_cu.sv
// Multi-cycle control unit for the RV32I-subset CPU with the custom HAMD instruction.
// Sequences IF/ID/EX/MEM/WB(/EXW) and handshakes with memory and the HAMD unit.
module mc_cu #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned HAMD_EN     = 1,
  parameter int unsigned HAMD_MC     = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] inst,
  input  logic        z,
  input  logic        mem_ready,
  input  logic        alu_done,
  output logic        pcwrite,
  output logic        irwrite,
  output logic        iord,
  output logic        rmem,
  output logic        wmem,
  output logic        wreg,
  output logic        m2reg,
  output logic [3:0]  aluc,
  output logic        aluimm,
  output logic        sext,
  output logic        i_lui,
  output logic        i_sw,
  output logic        shift,
  output logic [1:0]  pcsource,
  output logic        alu_start,
  output logic        trap,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_EXW  = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HAMD   = 7'b0001011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_HAMD = 4'b1111;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic HAMD_OK = (HAMD_EN != 0);
  localparam logic HAMD_W  = (HAMD_MC != 0);

  logic [2:0]       state_q;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] to_cnt;
  logic             trap_q;
  logic             timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       is_lw, is_sw, is_beq, is_bne, is_jal, is_jalr, is_hamd, is_lui;
  logic       dec_imm, dec_sext, dec_shift;
  logic [3:0] dec_aluc;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  // Instruction decode; anything not matched leaves legal=0 and traps in ID.
  always_comb begin : decode
    legal     = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_hamd   = 1'b0;
    is_lui    = 1'b0;
    dec_imm   = 1'b0;
    dec_sext  = 1'b0;
    dec_shift = 1'b0;
    dec_aluc  = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin legal = 1'b1; dec_aluc = ALU_ADD; end
            3'b001: begin legal = 1'b1; dec_aluc = ALU_SLL; dec_shift = 1'b1; end
            3'b100: begin legal = 1'b1; dec_aluc = ALU_XOR; end
            3'b101: begin legal = 1'b1; dec_aluc = ALU_SRL; dec_shift = 1'b1; end
            3'b110: begin legal = 1'b1; dec_aluc = ALU_OR;  end
            3'b111: begin legal = 1'b1; dec_aluc = ALU_AND; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000: begin legal = 1'b1; dec_aluc = ALU_SUB; end
            3'b101: begin legal = 1'b1; dec_aluc = ALU_SRA; dec_shift = 1'b1; end
            default: ;
          endcase
        end
      end
      OP_I: begin
        dec_imm  = 1'b1;
        dec_sext = 1'b1;
        case (funct3)
          3'b000: begin legal = 1'b1; dec_aluc = ALU_ADD; end
          3'b100: begin legal = 1'b1; dec_aluc = ALU_XOR; end
          3'b110: begin legal = 1'b1; dec_aluc = ALU_OR;  end
          3'b111: begin legal = 1'b1; dec_aluc = ALU_AND; end
          3'b001: begin
            legal = (funct7 == 7'b0000000); dec_aluc = ALU_SLL; dec_shift = 1'b1;
          end
          3'b101: begin
            legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            dec_aluc  = funct7[5] ? ALU_SRA : ALU_SRL;
            dec_shift = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LOAD: begin
        legal = (funct3 == 3'b010); is_lw = legal; dec_imm = 1'b1; dec_sext = 1'b1;
      end
      OP_STORE: begin
        legal = (funct3 == 3'b010); is_sw = legal; dec_imm = 1'b1; dec_sext = 1'b1;
      end
      OP_BRANCH: begin
        is_beq   = (funct3 == 3'b000);
        is_bne   = (funct3 == 3'b001);
        legal    = is_beq | is_bne;
        dec_aluc = ALU_SUB;
        dec_sext = 1'b1;
      end
      OP_LUI: begin
        legal = 1'b1; is_lui = 1'b1; dec_imm = 1'b1; dec_aluc = ALU_LUI;
      end
      OP_JAL: begin
        legal = 1'b1; is_jal = 1'b1; dec_sext = 1'b1;
      end
      OP_JALR: begin
        legal = (funct3 == 3'b000); is_jalr = legal; dec_imm = 1'b1; dec_sext = 1'b1;
      end
      OP_HAMD: begin
        if (HAMD_OK && funct3 == 3'b000 && funct7 == 7'b0000000) begin
          legal = 1'b1; is_hamd = 1'b1; dec_aluc = ALU_HAMD;
        end
      end
      default: ;
    endcase
  end

  assign timeout_hit = TO_EN && (to_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IF;
    else         state_q <= state_next;
  end

  // Next-state logic.
  always_comb begin : next_state_logic
    state_next = state_q;
    case (state_q)
      S_IF: begin
        if (mem_ready)        state_next = S_ID;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_ID: state_next = legal ? S_EX : S_TRAP;
      S_EX: begin
        if (is_beq || is_bne)       state_next = S_IF;
        else if (is_lw || is_sw)    state_next = S_MEM;
        else if (is_hamd && HAMD_W) state_next = S_EXW;
        else                        state_next = S_WB;
      end
      S_EXW: if (alu_done) state_next = S_WB;
      S_MEM: begin
        if (mem_ready)        state_next = is_lw ? S_WB : S_IF;
        else if (timeout_hit) state_next = S_TRAP;
      end
      S_WB:    state_next = S_IF;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase
  end

  // Memory wait counter: counts stalled IF/MEM cycles, cleared on any state change.
  always_ff @(posedge clock) begin
    if (!resetn)                       to_cnt <= '0;
    else if (state_next != state_q)    to_cnt <= '0;
    else if ((state_q == S_IF || state_q == S_MEM) && !mem_ready)
                                       to_cnt <= to_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn)                     trap_q <= 1'b0;
    else if (state_next == S_TRAP)   trap_q <= 1'b1;
  end

  // Output logic; every strobe is forced low while reset is asserted.
  always_comb begin : output_logic
    pcwrite   = 1'b0;
    irwrite   = 1'b0;
    iord      = 1'b0;
    rmem      = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    alu_start = 1'b0;
    pcsource  = 2'b00;
    aluc      = (state_q == S_EXW) ? ALU_HAMD : dec_aluc;
    if (resetn) begin
      case (state_q)
        S_IF: begin
          rmem = 1'b1;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
          end
        end
        S_EX: begin
          if (is_beq || is_bne) begin
            pcsource = 2'b01;
            pcwrite  = (is_beq & z) | (is_bne & ~z);
          end else if (is_jal) begin
            pcsource = 2'b11;
            pcwrite  = 1'b1;
          end else if (is_jalr) begin
            pcsource = 2'b10;
            pcwrite  = 1'b1;
          end else if (is_hamd && HAMD_W) begin
            alu_start = 1'b1;
          end
        end
        S_MEM: begin
          iord = 1'b1;
          rmem = is_lw;
          wmem = is_sw;
        end
        S_WB: wreg = 1'b1;
        default: ;
      endcase
    end
  end

  assign m2reg  = is_lw;
  assign aluimm = dec_imm;
  assign sext   = dec_sext;
  assign i_lui  = is_lui;
  assign i_sw   = is_sw;
  assign shift  = dec_shift;
  assign trap   = trap_q;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: the driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against two DUT configurations.
module tb_mc_cu;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  localparam logic [31:0] ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] LW   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] SW   = 32'h0050A023;  // sw x5,0(x1)
  localparam logic [31:0] BEQ  = 32'h00208063;  // beq x1,x2,0
  localparam logic [31:0] JAL  = 32'h000000EF;  // jal x1,0
  localparam logic [31:0] HAMD = 32'h0020818B;  // hamd x3,x1,x2
  localparam logic [31:0] SLT  = 32'h0020A1B3;  // slt (unsupported)

  // {aluc, aluimm, sext, i_lui, i_sw, shift, m2reg}
  localparam logic [9:0] D_ADD  = 10'b0000_0_0_0_0_0_0;
  localparam logic [9:0] D_LW   = 10'b0000_1_1_0_0_0_1;
  localparam logic [9:0] D_SW   = 10'b0000_1_1_0_1_0_0;
  localparam logic [9:0] D_BEQ  = 10'b1000_0_1_0_0_0_0;
  localparam logic [9:0] D_JAL  = 10'b0000_0_1_0_0_0_0;
  localparam logic [9:0] D_HAMD = 10'b1111_0_0_0_0_0_0;
  localparam logic [10:0] NOD = 11'b0;
  localparam logic [4:0]  NON = 5'b0;

  logic clock = 1'b0;
  logic resetn, z, mem_ready, alu_done;
  logic [31:0] inst;

  logic pcwrite, irwrite, iord, rmem, wmem, wreg, m2reg, aluimm, sext, i_lui, i_sw, shift;
  logic alu_start, trap;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;

  logic nh_pcwrite, nh_irwrite, nh_iord, nh_rmem, nh_wmem, nh_wreg, nh_m2reg, nh_aluimm;
  logic nh_sext, nh_i_lui, nh_i_sw, nh_shift, nh_alu_start, nh_trap;
  logic [3:0] nh_aluc;
  logic [1:0] nh_pcsource;
  logic [2:0] nh_state;

  always #5 clock = ~clock;

  mc_cu #(.MEM_TIMEOUT(4), .HAMD_EN(1), .HAMD_MC(1)) dut (
    .clock(clock), .resetn(resetn), .inst(inst), .z(z), .mem_ready(mem_ready),
    .alu_done(alu_done), .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .rmem(rmem),
    .wmem(wmem), .wreg(wreg), .m2reg(m2reg), .aluc(aluc), .aluimm(aluimm), .sext(sext),
    .i_lui(i_lui), .i_sw(i_sw), .shift(shift), .pcsource(pcsource), .alu_start(alu_start),
    .trap(trap), .state(state)
  );

  mc_cu #(.MEM_TIMEOUT(4), .HAMD_EN(0), .HAMD_MC(1)) dut_nh (
    .clock(clock), .resetn(resetn), .inst(inst), .z(z), .mem_ready(mem_ready),
    .alu_done(alu_done), .pcwrite(nh_pcwrite), .irwrite(nh_irwrite), .iord(nh_iord),
    .rmem(nh_rmem), .wmem(nh_wmem), .wreg(nh_wreg), .m2reg(nh_m2reg), .aluc(nh_aluc),
    .aluimm(nh_aluimm), .sext(nh_sext), .i_lui(nh_i_lui), .i_sw(nh_i_sw), .shift(nh_shift),
    .pcsource(nh_pcsource), .alu_start(nh_alu_start), .trap(nh_trap), .state(nh_state)
  );

  string       name_q[$];
  logic [13:0] ctl_q[$];
  logic [10:0] dec_q[$];
  logic [4:0]  nh_q[$];
  logic        done = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  // {state, pcwrite, irwrite, iord, rmem, wmem, wreg, alu_start, pcsource, trap}
  function automatic logic [13:0] C(input logic [2:0] s, input logic [6:0] strb,
                                    input logic [1:0] ps, input logic tr);
    return {s, strb, ps, tr};
  endfunction

  task automatic step(input string nm, input logic rst, input logic [31:0] i,
                      input logic zz, input logic mr, input logic ad,
                      input logic [13:0] ectl, input logic [10:0] edec, input logic [4:0] enh);
    resetn = rst; inst = i; z = zz; mem_ready = mr; alu_done = ad;
    name_q.push_back(nm);
    ctl_q.push_back(ectl);
    dec_q.push_back(edec);
    nh_q.push_back(enh);
    @(posedge clock); #1;
  endtask

  // Monitor: compares whatever the DUTs present against the queued expectation.
  always @(negedge clock) begin
    string nm;
    logic [13:0] ectl, actl;
    logic [10:0] edec;
    logic [9:0]  adec;
    logic [4:0]  enh;
    logic [3:0]  anh;
    if (ctl_q.size() != 0) begin
      nm   = name_q.pop_front();
      ectl = ctl_q.pop_front();
      edec = dec_q.pop_front();
      enh  = nh_q.pop_front();
      actl = {state, pcwrite, irwrite, iord, rmem, wmem, wreg, alu_start, pcsource, trap};
      n_tests++;
      if (actl !== ectl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b", nm, actl, ectl);
      end
      if (edec[10]) begin
        adec = {aluc, aluimm, sext, i_lui, i_sw, shift, m2reg};
        n_tests++;
        if (adec !== edec[9:0]) begin
          n_fail++;
          $display("FAIL %s dec: got %b expected %b", nm, adec, edec[9:0]);
        end
      end
      if (enh[4]) begin
        anh = {nh_state, nh_trap};
        n_tests++;
        if (anh !== enh[3:0]) begin
          n_fail++;
          $display("FAIL %s nohamd: got %b expected %b", nm, anh, enh[3:0]);
        end
      end
    end else if (done) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    resetn = L; inst = ADD; z = L; mem_ready = H; alu_done = L;
    repeat (2) @(posedge clock);
    #1;
    step("reset", L, ADD, L, H, L, C(3'd0, 7'b0000000, 2'b00, L), {H, D_ADD}, {H, 3'd0, L});

    // add: IF ID EX WB, back in IF on the fifth cycle
    step("add_if", H, ADD, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("add_id", H, ADD, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), {H, D_ADD}, NON);
    step("add_ex", H, ADD, L, H, L, C(3'd2, 7'b0000000, 2'b00, L), {H, D_ADD}, NON);
    step("add_wb", H, ADD, L, H, L, C(3'd4, 7'b0000010, 2'b00, L), {H, D_ADD}, NON);

    // lw with three wait cycles in MEM
    step("lw_if", H, LW, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("lw_id", H, LW, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), {H, D_LW}, NON);
    step("lw_ex", H, LW, L, H, L, C(3'd2, 7'b0000000, 2'b00, L), NOD, NON);
    for (int k = 0; k < 3; k++)
      step("lw_mem_wait", H, LW, L, L, L, C(3'd3, 7'b0011000, 2'b00, L), {H, D_LW}, NON);
    step("lw_mem_done", H, LW, L, H, L, C(3'd3, 7'b0011000, 2'b00, L), NOD, NON);
    step("lw_wb", H, LW, L, H, L, C(3'd4, 7'b0000010, 2'b00, L), {H, D_LW}, NON);

    // beq taken then not taken
    step("beq1_if", H, BEQ, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("beq1_id", H, BEQ, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), NOD, NON);
    step("beq1_ex", H, BEQ, H, H, L, C(3'd2, 7'b1000000, 2'b01, L), {H, D_BEQ}, NON);
    step("beq0_if", H, BEQ, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("beq0_id", H, BEQ, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), NOD, NON);
    step("beq0_ex", H, BEQ, L, H, L, C(3'd2, 7'b0000000, 2'b01, L), {H, D_BEQ}, NON);

    // jal: jump in EX, link write in WB
    step("jal_if", H, JAL, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("jal_id", H, JAL, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), NOD, NON);
    step("jal_ex", H, JAL, L, H, L, C(3'd2, 7'b1000000, 2'b11, L), {H, D_JAL}, NON);
    step("jal_wb", H, JAL, L, H, L, C(3'd4, 7'b0000010, 2'b00, L), NOD, NON);

    // sw completing with zero-wait memory
    step("sw_if", H, SW, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("sw_id", H, SW, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), {H, D_SW}, NON);
    step("sw_ex", H, SW, L, H, L, C(3'd2, 7'b0000000, 2'b00, L), NOD, NON);
    step("sw_mem", H, SW, L, H, L, C(3'd3, 7'b0010100, 2'b00, L), {H, D_SW}, NON);

    // hamd: alu_done in EX is ignored, five EXW cycles; HAMD-disabled copy traps from ID
    step("hamd_if", H, HAMD, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, {H, 3'd0, L});
    step("hamd_id", H, HAMD, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), {H, D_HAMD}, {H, 3'd1, L});
    step("hamd_ex", H, HAMD, L, H, H, C(3'd2, 7'b0000001, 2'b00, L), {H, D_HAMD}, {H, 3'd7, H});
    for (int k = 0; k < 4; k++)
      step("hamd_exw", H, HAMD, L, H, L, C(3'd5, 7'b0000000, 2'b00, L), {H, D_HAMD}, {H, 3'd7, H});
    step("hamd_exw_done", H, HAMD, L, H, H, C(3'd5, 7'b0000000, 2'b00, L), {H, D_HAMD}, NON);
    step("hamd_wb", H, HAMD, L, H, L, C(3'd4, 7'b0000010, 2'b00, L), {H, D_HAMD}, NON);

    // fetch timeout after four stalled IF cycles, sticky until reset
    for (int k = 0; k < 4; k++)
      step("to_if_wait", H, ADD, L, L, L, C(3'd0, 7'b0001000, 2'b00, L), NOD, NON);
    step("trap_a", H, ADD, L, H, H, C(3'd7, 7'b0000000, 2'b00, H), NOD, NON);
    step("trap_b", H, ADD, H, H, L, C(3'd7, 7'b0000000, 2'b00, H), NOD, NON);
    step("trap_rst", L, ADD, L, H, L, C(3'd7, 7'b0000000, 2'b00, H), NOD, NON);
    step("post_rst_if", H, ADD, L, L, L, C(3'd0, 7'b0001000, 2'b00, L), NOD, NON);

    // reset asserted while sw waits in MEM
    step("swr_if", H, SW, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);
    step("swr_id", H, SW, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), NOD, NON);
    step("swr_ex", H, SW, L, H, L, C(3'd2, 7'b0000000, 2'b00, L), NOD, NON);
    step("swr_mem", H, SW, L, L, L, C(3'd3, 7'b0010100, 2'b00, L), {H, D_SW}, NON);
    step("swr_rst", L, SW, L, L, L, C(3'd3, 7'b0000000, 2'b00, L), NOD, NON);
    step("swr_after_if", H, SLT, L, H, L, C(3'd0, 7'b1101000, 2'b00, L), NOD, NON);

    // unsupported funct traps from ID
    step("ill_id", H, SLT, L, H, L, C(3'd1, 7'b0000000, 2'b00, L), NOD, NON);
    step("ill_trap", H, SLT, L, H, L, C(3'd7, 7'b0000000, 2'b00, H), NOD, NON);

    done = 1'b1;
    repeat (20) @(posedge clock);
    $display("FAIL tb_timeout: monitor did not drain, got %0d queued expected 0", ctl_q.size());
    $fatal(1, "bench did not complete");
  end

endmodule
